// File: rtl/mmm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmm_pkg
//  Description : Shared types and helpers for the Montgomery modular
//                multiplier operand shift register.
//                - mmm_sreg_state_t : operand register FSM states
//                - mmm_nslice()     : number of shift steps per operand pass
//  Revision    : 1.0  initial release
// ============================================================================
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } mmm_sreg_state_t;

  // Slices per pass; usable in localparam context.
  function automatic int mmm_nslice(input int width, input int shift);
    return width / shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmm_operand_sreg_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmm_operand_sreg_if
//  Description : Load handshake, control and slice-output bundle of the MMM
//                operand shift register.
//                master : drives en, clr, ld_valid, lock, reg_rji, A, shift
//                slave  : drives ld_ready, R_i, r_lsb, busy, last, done
//  Revision    : 1.0  initial release
// ============================================================================
interface mmm_operand_sreg_if #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
);
  import mmm_pkg::*;

  logic             en;
  logic             clr;
  logic             ld_valid;
  logic             ld_ready;
  logic             lock;
  logic [WIDTH-1:0] reg_rji;
  logic [WIDTH-1:0] A;
  logic             shift;
  logic [WIDTH-1:0] R_i;
  logic [SHIFT-1:0] r_lsb;
  logic             busy;
  logic             last;
  logic             done;

  modport master (
    output en, clr, ld_valid, lock, reg_rji, A, shift,
    input  ld_ready, R_i, r_lsb, busy, last, done
  );

  modport slave (
    input  en, clr, ld_valid, lock, reg_rji, A, shift,
    output ld_ready, R_i, r_lsb, busy, last, done
  );

endinterface
`default_nettype wire

// File: rtl/mmm_operand_sreg.sv
`default_nettype none
// ============================================================================
//  Module      : mmm_operand_sreg
//  Description : Operand register for the MMM datapath. Loads one WIDTH-bit
//                operand (A or the fed-back reg_rji, chosen by lock) and
//                shifts it out SHIFT bits per step, LSB first.
//  Ports       : clk   - rising-edge clock
//                rstb  - asynchronous active-low reset
//                bus   - mmm_operand_sreg_if.slave (enable, clear, load
//                        handshake, shift request, operand/slice outputs and
//                        busy/last/done flags)
//  Revision    : 1.0  initial release
// ============================================================================
module mmm_operand_sreg
  import mmm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SHIFT  = 1,
  parameter int ROTATE = 0
) (
  input  wire logic            clk,
  input  wire logic            rstb,
  mmm_operand_sreg_if.slave    bus
);

  localparam int NSLICE = mmm_nslice(WIDTH, SHIFT);
  localparam int CNT_W  = $clog2(NSLICE) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  mmm_sreg_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] shifted_w;
  logic [WIDTH-1:0] ld_data_w;

  // Operand after one shift step. A single slice spanning the whole word
  // has no remaining bits to move down, so it gets its own branch.
  if (SHIFT == WIDTH) begin : g_full
    if (ROTATE != 0) begin : g_full_rot
      assign shifted_w = r_q;
    end else begin : g_full_zero
      assign shifted_w = '0;
    end
  end else if (ROTATE != 0) begin : g_rot
    assign shifted_w = {r_q[SHIFT-1:0], r_q[WIDTH-1:SHIFT]};
  end else begin : g_zero
    assign shifted_w = {{SHIFT{1'b0}}, r_q[WIDTH-1:SHIFT]};
  end

  assign ld_data_w = bus.lock ? bus.reg_rji : bus.A;

  // Next-state logic. clr outranks en so a per-multiplication clear works
  // even while the datapath is stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      r_d     = '0;
    end else if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.ld_valid) begin
            r_d     = ld_data_w;
            cnt_d   = '0;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.shift) begin
            r_d = shifted_w;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // A load here chains straight into the next pass.
          if (bus.ld_valid) begin
            r_d     = ld_data_w;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  assign bus.ld_ready = bus.en && (state_q != ACTIVE);
  assign bus.R_i      = r_q;
  assign bus.r_lsb    = r_q[SHIFT-1:0];
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.last     = (state_q == ACTIVE) && (cnt_q == CNT_LAST);
  assign bus.done     = (state_q == DONE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (WIDTH % SHIFT == 0)
      else $error("WIDTH must be a multiple of SHIFT");
    if (rstb && bus.en && !bus.clr && bus.shift)
      assert (state_q == ACTIVE)
        else $warning("shift ignored while not busy");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmm_operand_sreg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmm_operand_sreg
//  Description : Bench for mmm_operand_sreg. Three instances share one
//                stimulus stream: (SHIFT=1, zero-fill), (SHIFT=1, rotate)
//                and (SHIFT=2, zero-fill). Each has its own reference model
//                and slice scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmm_operand_sreg;
  import mmm_pkg::*;

  logic       clk;
  logic       rstb;
  logic       tb_en, tb_clr, tb_ld_valid, tb_lock, tb_shift;
  logic [7:0] tb_rji, tb_a;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  // Register contents after k slices of a pass over operand op.
  function automatic logic [7:0] exp_r(input logic [7:0] op, input int k,
                                       input int sh, input int rot);
    int          s;
    logic [15:0] d;
    s = k * sh;
    if (rot != 0) begin
      d = {op, op};
      s = s % 8;
    end else begin
      d = {8'h00, op};
    end
    d = d >> s;
    return d[7:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SH = (g == 2) ? 2 : 1;
    localparam int RO = (g == 1) ? 1 : 0;
    localparam int NS = 8 / SH;

    mmm_operand_sreg_if #(.WIDTH(8), .SHIFT(SH)) ifc ();

    assign ifc.en       = tb_en;
    assign ifc.clr      = tb_clr;
    assign ifc.ld_valid = tb_ld_valid;
    assign ifc.lock     = tb_lock;
    assign ifc.reg_rji  = tb_rji;
    assign ifc.A        = tb_a;
    assign ifc.shift    = tb_shift;

    mmm_operand_sreg #(.WIDTH(8), .SHIFT(SH), .ROTATE(RO)) u_dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (ifc.slave)
    );

    // Reference model: mode 0 = idle, 1 = passing, 2 = pass just finished.
    int         mode = 0;
    int         k    = 0;
    logic [7:0] op   = '0;
    logic [7:0] sq[$];

    task automatic do_load();
      op   = tb_lock ? tb_rji : tb_a;
      k    = 0;
      mode = 1;
      sq.delete();
      for (int j = 0; j < NS; j++)
        sq.push_back((op >> (j * SH)) & 8'((1 << SH) - 1));
    endtask

    always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        mode = 0; op = '0; k = 0; sq.delete();
      end else if (tb_clr) begin
        mode = 0; op = '0; k = 0; sq.delete();
      end else if (tb_en) begin
        case (mode)
          0: if (tb_ld_valid) do_load();
          1: if (tb_shift) begin
               k++;
               if (k == NS) mode = 2;
             end
          default: if (tb_ld_valid) do_load(); else mode = 0;
        endcase
      end
    end

    always @(negedge clk) begin
      logic [7:0] er;
      logic [7:0] es;
      er = exp_r(op, k, SH, RO);
      chk("R_i",      g, 32'(ifc.R_i),      32'(er));
      chk("r_lsb",    g, 32'(ifc.r_lsb),    32'(er & 8'((1 << SH) - 1)));
      chk("busy",     g, 32'(ifc.busy),     32'(mode == 1));
      chk("done",     g, 32'(ifc.done),     32'(mode == 2));
      chk("last",     g, 32'(ifc.last),     32'(mode == 1 && k == NS - 1));
      chk("ld_ready", g, 32'(ifc.ld_ready), 32'(tb_en && mode != 1));
      // Scoreboard: a slice is consumed at the coming edge.
      if (rstb && ifc.busy && tb_en && !tb_clr && tb_shift) begin
        if (sq.size() == 0) begin
          chk("slice_queue_empty", g, 32'd1, 32'd0);
        end else begin
          es = sq.pop_front();
          chk("slice_sb", g, 32'(ifc.r_lsb), 32'(es));
          chk("last_sb",  g, 32'(ifc.last),  32'(sq.size() == 0));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tb_ld_valid = 1'b0;
    tb_shift    = 1'b0;
    tb_clr      = 1'b0;
    tb_en       = 1'b1;
  endtask

  task automatic load(input logic lk, input logic [7:0] rji, input logic [7:0] a);
    tb_lock = lk; tb_rji = rji; tb_a = a; tb_ld_valid = 1'b1; tb_shift = 1'b0;
    cyc();
    tb_ld_valid = 1'b0;
  endtask

  task automatic shifts(input int n);
    tb_shift = 1'b1;
    repeat (n) cyc();
    tb_shift = 1'b0;
  endtask

  logic [7:0] lit_seq;

  initial begin
    rstb = 1'b0;
    tb_en = 1'b1; tb_clr = 1'b0; tb_ld_valid = 1'b0; tb_lock = 1'b0;
    tb_shift = 1'b0; tb_rji = '0; tb_a = '0;
    repeat (3) cyc();
    chk("reset_R_i",      0, 32'(g_dut[0].ifc.R_i),      32'h0);
    chk("reset_ld_ready", 0, 32'(g_dut[0].ifc.ld_ready), 32'h1);
    rstb = 1'b1;
    cyc();

    // Load 0xA5 from A, then a full pass on the 1-bit instances.
    load(1'b0, 8'h00, 8'hA5);
    chk("load_A5", 0, 32'(g_dut[0].ifc.R_i), 32'hA5);
    lit_seq = 8'b1010_0101;
    tb_shift = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("seq_bit", 0, 32'(g_dut[0].ifc.r_lsb), 32'(lit_seq[i]));
      if (i == 7) chk("last_8th", 0, 32'(g_dut[0].ifc.last), 32'h1);
      cyc();
    end
    tb_shift = 1'b0;
    chk("done_pulse", 0, 32'(g_dut[0].ifc.done), 32'h1);
    chk("final_zero", 0, 32'(g_dut[0].ifc.R_i),  32'h0);
    chk("final_rot",  1, 32'(g_dut[1].ifc.R_i),  32'hA5);
    cyc();
    chk("done_one_cycle", 0, 32'(g_dut[0].ifc.done), 32'h0);

    // Load from reg_rji; loads during the pass are ignored.
    load(1'b1, 8'h3C, 8'hFF);
    chk("load_rji", 0, 32'(g_dut[0].ifc.R_i), 32'h3C);
    tb_lock = 1'b0; tb_a = 8'h11; tb_ld_valid = 1'b1;
    repeat (2) cyc();
    tb_ld_valid = 1'b0;
    chk("ignored_load", 0, 32'(g_dut[0].ifc.R_i), 32'h3C);
    shifts(8);

    // Back-to-back: load accepted in the DONE cycle.
    cyc();
    load(1'b0, 8'h00, 8'hA5);
    shifts(8);
    load(1'b0, 8'h00, 8'h5A);
    chk("b2b_busy", 1, 32'(g_dut[1].ifc.busy), 32'h1);
    chk("b2b_R_i",  1, 32'(g_dut[1].ifc.R_i),  32'h5A);
    shifts(8);
    cyc();

    // Stall mid-pass, then clear with and without en.
    load(1'b0, 8'h00, 8'hC3);
    shifts(3);
    tb_en = 1'b0; tb_shift = 1'b1;
    repeat (5) cyc();
    tb_shift = 1'b0; tb_en = 1'b1; tb_clr = 1'b1;
    cyc();
    tb_clr = 1'b0;
    chk("clr_R_i", 0, 32'(g_dut[0].ifc.R_i), 32'h0);
    load(1'b0, 8'h00, 8'h96);
    shifts(3);
    tb_en = 1'b0; tb_clr = 1'b1;
    cyc();
    tb_en = 1'b1; tb_clr = 1'b0;
    chk("clr_noen_busy", 0, 32'(g_dut[0].ifc.busy), 32'h0);
    cyc();

    // Asynchronous reset between clock edges.
    load(1'b0, 8'h00, 8'hE7);
    shifts(2);
    #3 rstb = 1'b0;
    #1;
    chk("async_R_i",  0, 32'(g_dut[0].ifc.R_i),  32'h0);
    chk("async_busy", 0, 32'(g_dut[0].ifc.busy), 32'h0);
    repeat (2) cyc();
    rstb = 1'b1;
    chk("post_rst_ld_ready", 0, 32'(g_dut[0].ifc.ld_ready), 32'h1);
    load(1'b0, 8'h00, 8'h81);
    chk("post_rst_load", 0, 32'(g_dut[0].ifc.R_i), 32'h81);
    shifts(8);
    idle_inputs();
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      tb_ld_valid = ($urandom_range(0, 9) < 3);
      tb_shift    = ($urandom_range(0, 9) < 7);
      tb_en       = ($urandom_range(0, 9) != 0);
      tb_clr      = ($urandom_range(0, 49) == 0);
      tb_lock     = 1'($urandom);
      tb_rji      = 8'($urandom);
      tb_a        = 8'($urandom);
      cyc();
    end
    idle_inputs();
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
